// File: rtl/instr_fetch_unit.sv
// Fetch stage: drives IRAM addresses, absorbs the 1-cycle read latency and
// presents opcode (+ optional operand) to decode over a valid/ready handshake.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [15:0] iram_addr,
    input  logic [15:0] iram_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_opcode,
    output logic [15:0] instr_operand,
    output logic        instr_has_operand,
    output logic [15:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        busy,
    output logic        halted
);

    localparam int unsigned W = 16;
    localparam logic [W-1:0] ENDOP = W'(40);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_OP  = 3'd1,
        CAP_OP  = 3'd2,
        REQ_OPD = 3'd3,
        CAP_OPD = 3'd4,
        ISSUE   = 3'd5,
        HALT    = 3'd6
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   pc;
    logic           redirect_take;
    logic           op_two_word;

    // Opcodes that carry a second (operand) word.
    function automatic logic is_two_word(input logic [W-1:0] op);
        case (op)
            W'(7), W'(11), W'(19), W'(28), W'(33),
            W'(35), W'(45), W'(51), W'(57), W'(63): is_two_word = 1'b1;
            default:                                is_two_word = 1'b0;
        endcase
    endfunction

    assign op_two_word   = is_two_word(iram_data);
    assign redirect_take = redirect_valid && (state != IDLE) && (state != HALT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect overrides every active state.
    always_comb begin
        state_next = state;
        if (redirect_take) begin
            state_next = REQ_OP;
        end else begin
            case (state)
                IDLE:    if (start) state_next = REQ_OP;
                REQ_OP:  state_next = CAP_OP;
                CAP_OP:  state_next = op_two_word ? REQ_OPD : ISSUE;
                REQ_OPD: state_next = CAP_OPD;
                CAP_OPD: state_next = ISSUE;
                ISSUE: begin
                    if (instr_ready) begin
                        state_next = (instr_opcode == ENDOP) ? HALT : REQ_OP;
                    end
                end
                HALT:    if (start) state_next = REQ_OP;
                default: state_next = IDLE;
            endcase
        end
    end

    // IRAM address: operand word lives at pc+1 with 16-bit wrap.
    always_comb begin
        iram_addr = pc;
        if ((state == REQ_OPD) || (state == CAP_OPD)) begin
            iram_addr = pc + W'(1);
        end
    end

    // Registered datapath and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc                <= RESET_PC;
            instr_opcode      <= '0;
            instr_operand     <= '0;
            instr_has_operand <= 1'b0;
            instr_pc          <= '0;
            instr_valid       <= 1'b0;
            busy              <= 1'b0;
            halted            <= 1'b0;
        end else begin
            instr_valid <= (state_next == ISSUE);
            busy        <= (state_next != IDLE) && (state_next != HALT);
            halted      <= (state_next == HALT);
            if (redirect_take) begin
                pc <= redirect_pc;
            end else begin
                case (state)
                    CAP_OP: begin
                        instr_opcode      <= iram_data;
                        instr_pc          <= pc;
                        instr_has_operand <= op_two_word;
                        if (!op_two_word) begin
                            instr_operand <= '0;
                        end
                    end
                    CAP_OPD: instr_operand <= iram_data;
                    ISSUE: begin
                        if (instr_ready) begin
                            pc <= pc + (instr_has_operand ? W'(2) : W'(1));
                        end
                    end
                    HALT: begin
                        if (start) begin
                            pc <= RESET_PC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Per-core fetch stage directly upstream of the instruction RAM.
- Drives the IRAM read address (PC) and absorbs the IRAM's 1-cycle synchronous read latency.
- Assembles opcode plus optional operand word into one instruction and hands it to the control/decode stage over a valid/ready handshake.
- Handles jump redirects and stops fetching after ENDOP.

Parameters:
- RESET_PC, 16'd0: PC loaded on reset and on restart from HALT.

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin fetching from current PC (IDLE), or restart at RESET_PC (HALT)
- iram_addr  output  16  IRAM read address
- iram_data  input  16  IRAM data_out; equals ram[addr sampled at previous edge]
- instr_valid  output  1  instruction fields valid
- instr_ready  input  1  consumer accepts instruction this cycle
- instr_opcode  output  16  opcode word
- instr_operand  output  16  operand word; 0 for single-word opcodes
- instr_has_operand  output  1  opcode is two-word
- instr_pc  output  16  address of the opcode word
- redirect_valid  input  1  jump taken; refetch from redirect_pc
- redirect_pc  input  16  jump target
- busy  output  1  state not IDLE/HALT
- halted  output  1  ENDOP accepted

Behaviour:
- Two-word opcodes (decimal): LDAC 7, STAC 11, ADDM 19, MULM 28, JUMP 33, JPNZ 35, LDA 45, LDB 51, LDC 57, STC 63.
- All other values, including unknown ones, are single-word and passed through unchanged. ENDOP = 40.
- States: IDLE, REQ_OP, CAP_OP, REQ_OPD, CAP_OPD, ISSUE, HALT.
- Reset (async, immediate): state=IDLE, pc=RESET_PC, all instr_* outputs=0, instr_valid=0, busy=0, halted=0. iram_addr=RESET_PC.
- iram_addr (combinational from state):
  - REQ_OPD/CAP_OPD: pc+1 (16-bit wrap).
  - All other states: pc.
- Transitions:
  - IDLE: start -> REQ_OP.
  - REQ_OP -> CAP_OP.
  - CAP_OP: latch iram_data into instr_opcode and set instr_pc=pc. Two-word opcode -> REQ_OPD; otherwise instr_operand=0 -> ISSUE.
  - REQ_OPD -> CAP_OPD.
  - CAP_OPD: latch iram_data into instr_operand -> ISSUE.
  - ISSUE: instr_valid=1; fields held stable while ready=0. On ready: pc += 1 or 2 (mod 2^16). If opcode==ENDOP -> HALT, else -> REQ_OP.
  - HALT: halted=1, instr_valid=0. start -> pc=RESET_PC, halted=0 -> REQ_OP.
- Latency: instr_valid rises 3 cycles after the start edge for single-word opcodes, 5 cycles for two-word.
- Throughput: one instruction per 3 cycles (single-word) or 5 cycles (two-word) under constant ready.
- Redirect (any state except IDLE/HALT) has priority over everything except reset:
  - Next edge: pc=redirect_pc, state=REQ_OP, instr_valid=0.
  - Any partial or held instruction is discarded.
  - If instr_ready and redirect_valid coincide in ISSUE, the instruction counts as accepted, but the PC comes from redirect_pc. This is normal JUMP/JPNZ handling.
  - A redirect on an ENDOP accept cycle goes to REQ_OP, not HALT.
- Redirect in IDLE/HALT is ignored.
- start outside IDLE/HALT is ignored.
- Operand fetch wraps: an opcode at 0xFFFF reads its operand from 0x0000.
- No writes are issued; the IRAM data_in is not driven by this block.

Test Plan:
- Program ram[0]=32, ram[1]=11, ram[2]=6, ram[3]=7, ram[4]=5, ready=1; pulse start.
  - Instruction 1: opcode 32, operand 0, has_operand 0, pc 0, valid 3 cycles after start.
  - Instruction 2: opcode 11, operand 6, has_operand 1, pc 1, 5 cycles later.
  - Instruction 3: opcode 7, operand 5, pc 3.
- Backpressure: hold ready=0 for 6 cycles with opcode 11/operand 6 presented.
  - valid stays 1, all fields stable, iram_addr unchanged.
  - Release ready: next instruction has pc 3.
- Redirect: redirect_valid with redirect_pc=14 during CAP_OPD of LDAC at pc 3, ram[14]=44.
  - LDAC is never issued.
  - Next issued instruction is opcode 44, pc 14.
- Halt: ram[98]=40; accept it.
  - halted=1, busy=0, valid stays 0, iram_addr frozen.
  - Then start -> next instruction has pc 0 (RESET_PC).
- Wrap: RESET_PC=16'hFFFF, ram[65535]=7, ram[0]=9.
  - Issues opcode 7, operand 9, pc 65535.
  - Next fetch from pc 1.
- Assert rst mid-CAP_OPD without a clock edge.
  - All outputs take reset values immediately.
  - After release and start, fetch restarts at RESET_PC.
